// File: rtl/conv_pkg.sv
// Shared constants for the streaming convolution datapath: sizes, derived
// feature-map geometry and the streamer FSM encoding.
package conv_pkg;

  localparam int word_length        = 8;
  localparam int double_word_length = 16;
  localparam int kernel_size        = 5;
  localparam int image_size         = 36;

  // Valid-conv edge rounded down to even (36-5+1 = 32)
  localparam int out_size = (image_size - kernel_size + 1) & ~1;
  localparam int N        = out_size * out_size;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic int bus_width(input int size, input int dw);
    return size * size * dw;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Accumulator-to-word requantizer: arithmetic shift, optional ReLU, then
// saturate into a signed word_length result. Purely combinational.
module requant_sat #(
  parameter int word_length        = 8,
  parameter int double_word_length = 16,
  parameter int shift              = 4,
  parameter int relu_en            = 1
) (
  input  logic signed [double_word_length-1:0] din,
  output logic signed [word_length-1:0]        dout
);

  localparam logic signed [double_word_length-1:0] MAXV =
    double_word_length'((1 << (word_length - 1)) - 1);
  localparam logic signed [double_word_length-1:0] MINV =
    double_word_length'(-(1 << (word_length - 1)));

  logic signed [double_word_length-1:0] t;

  always_comb begin
    t = din >>> shift;
    if ((relu_en != 0) && t[double_word_length-1])
      t = '0;
    if (t > MAXV)      dout = MAXV[word_length-1:0];
    else if (t < MINV) dout = MINV[word_length-1:0];
    else               dout = t[word_length-1:0];
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Captures the conv top's flat feature-map bus on load and streams it out one
// requantized element per cycle over valid/ready, with row/col tags.
module conv_result_streamer #(
  parameter int word_length        = conv_pkg::word_length,
  parameter int double_word_length = conv_pkg::double_word_length,
  parameter int out_size           = conv_pkg::out_size,
  parameter int shift              = 4,
  parameter int relu_en            = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                load,
  input  logic [out_size*out_size*double_word_length-1:0]     data_in,
  input  logic                                                out_ready,
  output logic                                                out_valid,
  output logic [word_length-1:0]                              data_out,
  output logic [double_word_length-1:0]                       raw_out,
  output logic [double_word_length-1:0]                       row,
  output logic [double_word_length-1:0]                       col,
  output logic                                                last,
  output logic                                                busy,
  output logic                                                done
);
  import conv_pkg::*;

  localparam int NUM_ELEM = out_size * out_size;
  localparam int BUS_W    = bus_width(out_size, double_word_length);
  localparam int IW       = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [double_word_length-1:0] IDX_LAST = double_word_length'(NUM_ELEM - 1);
  localparam logic [double_word_length-1:0] COL_LAST = double_word_length'(out_size - 1);

  logic [1:0]                                   state;
  logic [NUM_ELEM-1:0][double_word_length-1:0]  frame;
  logic [double_word_length-1:0]                idx;
  logic [IW-1:0]                                sel;
  logic                                         start;
  logic                                         idx_last;

  // load is only honoured between frames, so a stalled frame can't be clobbered
  assign start    = load && ((state == ST_IDLE) || (state == ST_DONE));
  assign idx_last = (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      frame <= '0;
      idx   <= '0;
      row   <= '0;
      col   <= '0;
    end else if (start) begin
      frame <= data_in;
      idx   <= '0;
      row   <= '0;
      col   <= '0;
      state <= ST_STREAM;
    end else begin
      case (state)
        ST_STREAM: begin
          if (out_ready) begin
            if (idx_last) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + 1'b1;
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output path is combinational off the frame and idx: no bubble per element
  assign sel       = idx[IW-1:0];
  assign raw_out   = frame[sel];
  assign out_valid = (state == ST_STREAM);
  assign busy      = (state == ST_STREAM);
  assign done      = (state == ST_DONE);
  assign last      = out_valid && idx_last;

  requant_sat #(
    .word_length        (word_length),
    .double_word_length (double_word_length),
    .shift              (shift),
    .relu_en            (relu_en)
  ) u_rq (
    .din  (raw_out),
    .dout (data_out)
  );

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: two instances (ReLU on/off) share
// stimulus; expected values come from hand constants and a floor-division model.
module tb_conv_result_streamer;

  localparam int WL = 8;
  localparam int DW = 16;
  localparam int OS = 32;
  localparam int NE = OS * OS;
  localparam int BW = NE * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [BW-1:0] data_in;
  logic          out_ready;

  logic          out_valid, last, busy, done;
  logic [WL-1:0] data_out;
  logic [DW-1:0] raw_out, row, col;

  logic          nr_valid, nr_last, nr_busy, nr_done;
  logic [WL-1:0] nr_data;
  logic [DW-1:0] nr_raw, nr_row, nr_col;

  logic [BW-1:0] frame_a, frame_b;
  int n_assert = 0;
  int n_fail   = 0;
  int hs       = 0;

  always #5 clk = ~clk;

  conv_result_streamer #(.word_length(WL), .double_word_length(DW), .out_size(OS),
                         .shift(4), .relu_en(1)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .out_ready(out_ready),
    .out_valid(out_valid), .data_out(data_out), .raw_out(raw_out), .row(row),
    .col(col), .last(last), .busy(busy), .done(done));

  conv_result_streamer #(.word_length(WL), .double_word_length(DW), .out_size(OS),
                         .shift(4), .relu_en(0)) dut_nr (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .out_ready(out_ready),
    .out_valid(nr_valid), .data_out(nr_data), .raw_out(nr_raw), .row(nr_row),
    .col(nr_col), .last(nr_last), .busy(nr_busy), .done(nr_done));

  function automatic logic [15:0] elem_a(input int i);
    case (i)
      0: return 16'h0135;
      1: return 16'hFF9C;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'(i * 97 - 20000);
    endcase
  endfunction

  function automatic logic [15:0] elem_b(input int i);
    return 16'(i * 31 + 5);
  endfunction

  // Reference requantizer: floor(e/16), ReLU, clamp to int8
  function automatic logic [7:0] rq(input logic [15:0] e, input bit relu);
    int v, t;
    v = int'($signed(e));
    if (v >= 0) t = v / 16;
    else        t = -((-v + 15) / 16);
    if (relu && t < 0) t = 0;
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
    return 8'(t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_elem(input int i, input logic [15:0] e);
    chk($sformatf("valid[%0d]", i), {31'd0, out_valid}, 32'd1);
    chk($sformatf("raw[%0d]", i), {16'd0, raw_out}, {16'd0, e});
    chk($sformatf("data[%0d]", i), {24'd0, data_out}, {24'd0, rq(e, 1'b1)});
    chk($sformatf("nr_data[%0d]", i), {24'd0, nr_data}, {24'd0, rq(e, 1'b0)});
    chk($sformatf("row[%0d]", i), {16'd0, row}, 32'(i / OS));
    chk($sformatf("col[%0d]", i), {16'd0, col}, 32'(i % OS));
    chk($sformatf("last[%0d]", i), {31'd0, last}, {31'd0, (i == NE - 1)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int exp_idx;
    for (int i = 0; i < NE; i++) begin
      frame_a[i*DW +: DW] = elem_a(i);
      frame_b[i*DW +: DW] = elem_b(i);
    end
    rst = 1'b1; load = 1'b0; out_ready = 1'b0; data_in = '0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_last", {31'd0, last}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_raw", {16'd0, raw_out}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Load frame A; valid appears one cycle later
    data_in = frame_a; load = 1'b1; out_ready = 1'b1;
    chk("pre_load_valid", {31'd0, out_valid}, 32'd0);
    tick();
    load = 1'b0;
    chk("e0_data", {24'd0, data_out}, 32'h13);
    chk("e0_raw", {16'd0, raw_out}, 32'h0135);
    chk("e0_busy", {31'd0, busy}, 32'd1);
    chk_elem(0, 16'h0135);
    if (out_valid) hs++;
    tick();
    chk("e1_relu", {24'd0, data_out}, 32'h00);
    chk("e1_norelu", {24'd0, nr_data}, 32'hF9);
    if (out_valid) hs++;
    tick();
    chk("e2_relu", {24'd0, data_out}, 32'h7F);
    chk("e2_norelu", {24'd0, nr_data}, 32'h7F);
    if (out_valid) hs++;
    tick();
    chk("e3_norelu", {24'd0, nr_data}, 32'h80);
    chk("e3_relu", {24'd0, data_out}, 32'h00);
    if (out_valid) hs++;
    tick();
    chk_elem(4, elem_a(4));
    if (out_valid) hs++;
    tick();

    // Stall at idx 5 for three cycles, with a stray load in the middle
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_elem(5, elem_a(5));
      chk("stall_busy", {31'd0, busy}, 32'd1);
      if (k == 1) begin
        load = 1'b1; data_in = frame_b;
      end
      tick();
      load = 1'b0;
    end
    out_ready = 1'b1;
    chk_elem(5, elem_a(5));
    if (out_valid) hs++;
    tick();
    chk("after_stall_raw", {16'd0, raw_out}, {16'd0, elem_a(6)});

    // Remainder of the frame, one handshake per cycle
    exp_idx = 6;
    budget  = 2 * NE;
    while (exp_idx < NE && budget > 0) begin
      chk_elem(exp_idx, elem_a(exp_idx));
      if (exp_idx == NE - 1) begin
        chk("final_row", {16'd0, row}, 32'd31);
        chk("final_col", {16'd0, col}, 32'd31);
        chk("final_last", {31'd0, last}, 32'd1);
      end
      if (out_valid && out_ready) hs++;
      tick();
      exp_idx++;
      budget--;
    end
    chk("frame_budget", 32'(budget > 0), 32'd1);
    chk("handshakes", 32'(hs), 32'(NE));

    // DONE cycle: pulse, no valid, and a load here restarts with no gap
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_valid", {31'd0, out_valid}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_last", {31'd0, last}, 32'd0);
    data_in = frame_b; load = 1'b1;
    tick();
    load = 1'b0;
    chk("restart_done", {31'd0, done}, 32'd0);
    chk_elem(0, elem_b(0));

    // Advance frame B to idx 500 then abort with an async reset
    for (int k = 0; k < 500; k++) tick();
    chk_elem(500, elem_b(500));
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_raw", {16'd0, raw_out}, 32'd0);
    chk("abort_nr_valid", {31'd0, nr_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    data_in = frame_a; load = 1'b1;
    tick();
    load = 1'b0;
    chk_elem(0, elem_a(0));
    tick();
    chk_elem(1, elem_a(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
